pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_edge_det.sv | 29 ++
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the PC sequencer: state encoding, PC width and
// the default reset PC.
package seq_pkg;

  localparam int unsigned PC_W = 8;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_EXC  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_edge_det.sv
// 1-bit rising-edge detector.
// Ports: clk, rst_n (synchronous, active-low), sig_i (level input),
//        rise_c (combinational pulse, high while sig_i=1 and history=0).
// History resets to 1 so a level held high through reset is not an edge.
module seq_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_c
);

  logic hist_q;
  logic hist_d;

  always_comb begin
    hist_d = sig_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise_c = sig_i & ~hist_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: HALT / RUN / STEP / EXC control of an 8-bit PC
// with load, single-step, exception capture and resume.
// Ports:
//   SYS_clk, SYS_rst (synchronous, active-low)
//   SEQ_run (level), SEQ_step / SEQ_load / SEQ_eret (rising-edge requests)
//   SEQ_pc_val (load value), SEQ_pc_next (datapath next PC)
//   SEQ_eh_flag (same-cycle exception flag)
//   SEQ_pc, SEQ_epc, SEQ_state, SEQ_exc (registered), SEQ_commit (comb.)
// Optional feature macro SEQ_BREAKPOINT_EN adds SEQ_bp_addr, SEQ_bp_on and
// the registered pulse SEQ_bp_hit.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            SYS_clk,
  input  logic            SYS_rst,
  input  logic            SEQ_run,
  input  logic            SEQ_step,
  input  logic            SEQ_load,
  input  logic [PC_W-1:0] SEQ_pc_val,
  input  logic [PC_W-1:0] SEQ_pc_next,
  input  logic            SEQ_eh_flag,
  input  logic            SEQ_eret,
`ifdef SEQ_BREAKPOINT_EN
  input  logic [PC_W-1:0] SEQ_bp_addr,
  input  logic            SEQ_bp_on,
  output logic            SEQ_bp_hit,
`endif
  output logic [PC_W-1:0] SEQ_pc,
  output logic            SEQ_commit,
  output logic [PC_W-1:0] SEQ_epc,
  output logic [1:0]      SEQ_state,
  output logic            SEQ_exc
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            exc_q, exc_d;
  logic            step_rise_c, load_rise_c, eret_rise_c;
  logic            commit_c;
  logic            bp_trig_c;

`ifdef SEQ_BREAKPOINT_EN
  logic bp_armed_q, bp_armed_d;
  logic bp_hit_q, bp_hit_d;
`endif

  seq_edge_det u_step_det (
    .clk(SYS_clk), .rst_n(SYS_rst), .sig_i(SEQ_step), .rise_c(step_rise_c)
  );
  seq_edge_det u_load_det (
    .clk(SYS_clk), .rst_n(SYS_rst), .sig_i(SEQ_load), .rise_c(load_rise_c)
  );
  seq_edge_det u_eret_det (
    .clk(SYS_clk), .rst_n(SYS_rst), .sig_i(SEQ_eret), .rise_c(eret_rise_c)
  );

  // Breakpoint trigger; only armed after the first commit following RUN entry.
  always_comb begin
    bp_trig_c = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_trig_c = (state_q == ST_RUN) && SEQ_bp_on && (pc_q == SEQ_bp_addr) &&
                bp_armed_q;
`endif
  end

  // Commit qualifier is zero-latency; reset and breakpoints suppress it.
  always_comb begin
    commit_c = SYS_rst && ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
               !SEQ_eh_flag && !bp_trig_c;
  end

  // Next-state and PC/EPC update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    unique case (state_q)
      ST_HALT: begin
        if (load_rise_c) begin
          pc_d = SEQ_pc_val;
        end else if (SEQ_run) begin
          state_d = ST_RUN;
        end else if (step_rise_c) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (bp_trig_c) begin
          state_d = ST_HALT;
        end else if (SEQ_eh_flag) begin
          epc_d   = pc_q;
          state_d = ST_EXC;
        end else begin
          pc_d = SEQ_pc_next;
          if (!SEQ_run) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_STEP: begin
        if (SEQ_eh_flag) begin
          epc_d   = pc_q;
          state_d = ST_EXC;
        end else begin
          pc_d    = SEQ_pc_next;
          state_d = ST_HALT;
        end
      end
      ST_EXC: begin
        if (load_rise_c) begin
          pc_d    = SEQ_pc_val;
          state_d = ST_HALT;
        end else if (eret_rise_c) begin
          pc_d    = epc_q + PC_W'(1);
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    exc_d = (state_d == ST_EXC);
  end

`ifdef SEQ_BREAKPOINT_EN
  // Arm after a commit; disarm on every entry into RUN so a restart executes
  // the instruction sitting at the breakpoint.
  always_comb begin
    bp_armed_d = bp_armed_q;
    bp_hit_d   = bp_trig_c;
    if (commit_c) begin
      bp_armed_d = 1'b1;
    end
    if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
      bp_armed_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_rst) begin
      bp_armed_q <= 1'b0;
      bp_hit_q   <= 1'b0;
    end else begin
      bp_armed_q <= bp_armed_d;
      bp_hit_q   <= bp_hit_d;
    end
  end

  assign SEQ_bp_hit = bp_hit_q;
`endif

  always_ff @(posedge SYS_clk) begin
    if (!SYS_rst) begin
      state_q <= ST_HALT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
    end
  end

  assign SEQ_pc     = pc_q;
  assign SEQ_epc    = epc_q;
  assign SEQ_state  = state_q;
  assign SEQ_exc    = exc_q;
  assign SEQ_commit = commit_c;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table plus hand-built
// multi-cycle sequences, expectations queued when stimulus is driven.
module tb_pc_sequencer;

  localparam logic [1:0] H = 2'd0, R = 2'd1, S = 2'd2, E = 2'd3;

  logic       clk = 1'b0;
  logic       rst, run, step, load, eret, eh;
  logic [7:0] pc_val, pc_next;
  logic [7:0] pc, epc;
  logic       commit, exc;
  logic [1:0] state;
`ifdef SEQ_BREAKPOINT_EN
  logic [7:0] bp_addr;
  logic       bp_on, bp_hit;
`endif

  always #5 clk = ~clk;

  pc_sequencer dut (
    .SYS_clk(clk), .SYS_rst(rst), .SEQ_run(run), .SEQ_step(step),
    .SEQ_load(load), .SEQ_pc_val(pc_val), .SEQ_pc_next(pc_next),
    .SEQ_eh_flag(eh), .SEQ_eret(eret),
`ifdef SEQ_BREAKPOINT_EN
    .SEQ_bp_addr(bp_addr), .SEQ_bp_on(bp_on), .SEQ_bp_hit(bp_hit),
`endif
    .SEQ_pc(pc), .SEQ_commit(commit), .SEQ_epc(epc), .SEQ_state(state),
    .SEQ_exc(exc)
  );

  typedef struct {
    logic       rst, run, step, load, eret, eh;
    logic [7:0] val, nxt;
    logic       cm;
    logic [7:0] pc;
    logic [1:0] st;
    logic [7:0] epc;
  } vec_t;

  typedef struct {
    logic       cm;
    logic [7:0] pc;
    logic [1:0] st;
    logic [7:0] epc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rn, input logic sp,
                              input logic ld, input logic er, input logic e,
                              input logic [7:0] val, input logic [7:0] nxt,
                              input logic cm, input logic [7:0] p,
                              input logic [1:0] st, input logic [7:0] ep);
    vec_t v;
    v.rst = r; v.run = rn; v.step = sp; v.load = ld; v.eret = er; v.eh = e;
    v.val = val; v.nxt = nxt; v.cm = cm; v.pc = p; v.st = st; v.epc = ep;
    return v;
  endfunction

  // Drive one cycle: commit checked mid-cycle, registered outputs after edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    rst = v.rst; run = v.run; step = v.step; load = v.load; eret = v.eret;
    eh = v.eh; pc_val = v.val; pc_next = v.nxt;
    e.cm = v.cm; e.pc = v.pc; e.st = v.st; e.epc = v.epc;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, ".commit"}, {7'b0, commit}, {7'b0, sb[0].cm});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".state"}, {6'b0, state}, {6'b0, e.st});
    chk({tag, ".epc"}, epc, e.epc);
    chk({tag, ".exc"}, {7'b0, exc}, {7'b0, (e.st == E)});
  endtask

  vec_t       tbl[38];
  logic [7:0] mpc;

  initial begin
    rst = 1'b0; run = 1'b0; step = 1'b1; load = 1'b0; eret = 1'b0; eh = 1'b0;
    pc_val = 8'h00; pc_next = 8'h00;
`ifdef SEQ_BREAKPOINT_EN
    bp_addr = 8'h00; bp_on = 1'b0;
`endif
    //           rst run stp ld er eh val    nxt    cm pc     st epc
    tbl[0]  = mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, H, 8'h00);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, H, 8'h00);
    tbl[2]  = mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, H, 8'h00);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, H, 8'h00);
    tbl[4]  = mk(1, 0, 0, 1, 0, 0, 8'h10, 8'h00, 0, 8'h10, H, 8'h00);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 8'h33, 8'h00, 0, 8'h10, H, 8'h00);
    tbl[6]  = mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h11, 0, 8'h10, S, 8'h00);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h11, 1, 8'h11, H, 8'h00);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h12, 0, 8'h11, H, 8'h00);
    tbl[9]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h12, 0, 8'h11, R, 8'h00);
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h12, 1, 8'h12, R, 8'h00);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h13, 1, 8'h13, R, 8'h00);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h14, 1, 8'h14, R, 8'h00);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h15, 1, 8'h15, R, 8'h00);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h16, 1, 8'h16, H, 8'h00);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h17, 0, 8'h16, H, 8'h00);
    tbl[16] = mk(1, 0, 0, 1, 0, 0, 8'h20, 8'h00, 0, 8'h20, H, 8'h00);
    tbl[17] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h21, 0, 8'h20, R, 8'h00);
    tbl[18] = mk(1, 1, 0, 0, 0, 1, 8'h00, 8'h21, 0, 8'h20, E, 8'h20);
    tbl[19] = mk(1, 1, 0, 0, 0, 1, 8'h00, 8'h21, 0, 8'h20, E, 8'h20);
    tbl[20] = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h21, H, 8'h20);
    tbl[21] = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h21, H, 8'h20);
    tbl[22] = mk(1, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 8'hFF, H, 8'h20);
    tbl[23] = mk(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'hFF, S, 8'h20);
    tbl[24] = mk(1, 0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 8'hFF, E, 8'hFF);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hFF, E, 8'hFF);
    tbl[26] = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, H, 8'hFF);
    tbl[27] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 8'h00, R, 8'hFF);
    tbl[28] = mk(1, 1, 0, 0, 0, 1, 8'h00, 8'h01, 0, 8'h00, E, 8'h00);
    tbl[29] = mk(1, 0, 0, 1, 1, 0, 8'h42, 8'h00, 0, 8'h42, H, 8'h00);
    tbl[30] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h43, 0, 8'h42, R, 8'h00);
    tbl[31] = mk(1, 1, 0, 1, 0, 0, 8'h99, 8'h43, 1, 8'h43, R, 8'h00);
    tbl[32] = mk(1, 0, 0, 1, 0, 0, 8'h99, 8'h44, 1, 8'h44, H, 8'h00);
    tbl[33] = mk(1, 0, 0, 1, 0, 0, 8'h99, 8'h45, 0, 8'h44, H, 8'h00);
    tbl[34] = mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h45, 0, 8'h44, H, 8'h00);
    tbl[35] = mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h45, 0, 8'h44, R, 8'h00);
    tbl[36] = mk(0, 1, 0, 0, 0, 1, 8'h00, 8'h45, 0, 8'h00, H, 8'h00);
    tbl[37] = mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, H, 8'h00);

    @(posedge clk);
    #1;
    for (int i = 0; i < 38; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Free run from F8 with a +3 datapath: PC wraps modulo 256.
    apply(mk(1, 0, 0, 1, 0, 0, 8'hF8, 8'h00, 0, 8'hF8, H, 8'h00), "wrap.load");
    mpc = 8'hF8;
    apply(mk(1, 1, 0, 0, 0, 0, 8'h00, mpc + 8'd3, 0, mpc, R, 8'h00), "wrap.enter");
    for (int k = 0; k < 7; k++) begin
      logic [7:0] nx;
      nx = mpc + 8'd3;
      mpc = nx;
      apply(mk(1, (k != 6), 0, 0, 0, 0, 8'h00, nx, 1, nx, (k == 6) ? H : R, 8'h00),
            $sformatf("wrap%0d", k));
    end

`ifdef SEQ_BREAKPOINT_EN
    // Breakpoint at 05: halts once with a hit pulse, restart commits 05.
    bp_addr = 8'h05;
    bp_on   = 1'b1;
    apply(mk(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, H, 8'h00), "bp.load");
    mpc = 8'h00;
    apply(mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 8'h00, R, 8'h00), "bp.enter");
    for (int k = 0; k < 5; k++) begin
      logic [7:0] nx;
      nx = mpc + 8'd1;
      mpc = nx;
      apply(mk(1, 1, 0, 0, 0, 0, 8'h00, nx, 1, nx, R, 8'h00), $sformatf("bp.run%0d", k));
      chk("bp.nohit", {7'b0, bp_hit}, 8'h00);
    end
    apply(mk(1, 1, 0, 0, 0, 1, 8'h00, 8'h06, 0, 8'h05, H, 8'h00), "bp.trig");
    chk("bp.hit", {7'b0, bp_hit}, 8'h01);
    apply(mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h06, 0, 8'h05, R, 8'h00), "bp.reenter");
    chk("bp.hitpulse", {7'b0, bp_hit}, 8'h00);
    apply(mk(1, 1, 0, 0, 0, 0, 8'h00, 8'h06, 1, 8'h06, R, 8'h00), "bp.resume");
    apply(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h07, 1, 8'h07, H, 8'h00), "bp.stop");
    bp_on = 1'b0;
`endif

    chk("sb.empty", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
